// File: rtl/rx_lane_pattern_checker.sv
// Per-lane MBINIT data-to-clock pattern checker: compares each RX lane against a local LFSR
// and reports a per-lane pass vector. Optional feature macro: LANE_CHK_WORST_ERR_EN.
module rx_lane_pattern_checker #(
    parameter int NUM_LANES = 16,
    parameter int ITER_W    = 16,
    parameter int ERR_W     = 12
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 i_start_check,
    input  logic [ITER_W-1:0]    i_iterations,
    input  logic [ERR_W-1:0]     i_err_threshold,
    input  logic                 i_rx_valid,
    input  logic [NUM_LANES-1:0] i_rx_data,
    output logic [NUM_LANES-1:0] o_lane_result,
    output logic                 o_done_check,
    output logic                 o_busy
`ifdef LANE_CHK_WORST_ERR_EN
    ,
    output logic [ERR_W-1:0]     o_worst_lane_errs
`endif
);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t               state, state_nxt;
    logic [15:0]          lfsr;
    logic [ITER_W-1:0]    beat_cnt;
    logic [ITER_W-1:0]    iter_lat;
    logic [ERR_W-1:0]     thr_lat;
    logic [ERR_W-1:0]     err_cnt [NUM_LANES];
    logic [ERR_W-1:0]     err_upd [NUM_LANES];
    logic [NUM_LANES-1:0] expected;
    logic [NUM_LANES-1:0] mismatch;
    logic [NUM_LANES-1:0] lane_pass;
    logic                 beat_en;
    logic                 last_beat;
`ifdef LANE_CHK_WORST_ERR_EN
    logic [ERR_W-1:0]     worst_nxt;
`endif

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v, input logic inc);
        if (inc && (v != {ERR_W{1'b1}}))
            return v + ERR_W'(1);
        return v;
    endfunction

    // Compare stage: the final beat's mismatch is folded into err_upd so it counts toward the verdict
    always_comb begin
        expected  = '0;
        mismatch  = '0;
        lane_pass = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            expected[i]  = lfsr[4'(i % 16)];
            mismatch[i]  = i_rx_data[i] ^ expected[i];
            err_upd[i]   = sat_inc(err_cnt[i], mismatch[i]);
            lane_pass[i] = (err_upd[i] <= thr_lat);
        end
    end

`ifdef LANE_CHK_WORST_ERR_EN
    always_comb begin
        worst_nxt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (err_upd[i] > worst_nxt)
                worst_nxt = err_upd[i];
        end
    end
`endif

    assign beat_en   = (state == CHECK) && i_start_check && i_rx_valid;
    assign last_beat = beat_en && (beat_cnt == (iter_lat - ITER_W'(1)));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start_check)
                    state_nxt = (i_iterations == '0) ? DONE : CHECK;
            end
            CHECK: begin
                // Abort wins over a coincident last beat
                if (!i_start_check)
                    state_nxt = IDLE;
                else if (last_beat)
                    state_nxt = DONE;
            end
            DONE: begin
                if (!i_start_check)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Accumulate stage: counters, LFSR and registered outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            lfsr          <= LFSR_SEED;
            beat_cnt      <= '0;
            iter_lat      <= '0;
            thr_lat       <= '0;
            o_lane_result <= '0;
            o_done_check  <= 1'b0;
            o_busy        <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++)
                err_cnt[i] <= '0;
`ifdef LANE_CHK_WORST_ERR_EN
            o_worst_lane_errs <= '0;
`endif
        end else begin
            if ((state == IDLE) && i_start_check) begin
                lfsr     <= LFSR_SEED;
                beat_cnt <= '0;
                iter_lat <= i_iterations;
                thr_lat  <= i_err_threshold;
                for (int i = 0; i < NUM_LANES; i++)
                    err_cnt[i] <= '0;
                if (i_iterations == '0) begin
                    o_lane_result <= '1;
`ifdef LANE_CHK_WORST_ERR_EN
                    o_worst_lane_errs <= '0;
`endif
                end
            end else if (beat_en) begin
                lfsr     <= lfsr_next(lfsr);
                beat_cnt <= beat_cnt + ITER_W'(1);
                for (int i = 0; i < NUM_LANES; i++)
                    err_cnt[i] <= err_upd[i];
                if (last_beat) begin
                    o_lane_result <= lane_pass;
`ifdef LANE_CHK_WORST_ERR_EN
                    o_worst_lane_errs <= worst_nxt;
`endif
                end
            end
            o_done_check <= (state_nxt == DONE);
            o_busy       <= (state_nxt == CHECK);
        end
    end

endmodule

// File: tb/tb_rx_lane_pattern_checker.sv
// Randomized self-checking bench for rx_lane_pattern_checker against a per-lane error-count model.
module tb_rx_lane_pattern_checker;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        i_start_check;
    logic [15:0] i_iterations;
    logic [11:0] i_err_threshold;
    logic        i_rx_valid;
    logic [15:0] i_rx_data;
    logic [15:0] o_lane_result;
    logic        o_done_check;
    logic        o_busy;
`ifdef LANE_CHK_WORST_ERR_EN
    logic [11:0] o_worst_lane_errs;
`endif

    rx_lane_pattern_checker dut (
        .CLK             (CLK),
        .rst_n           (rst_n),
        .i_start_check   (i_start_check),
        .i_iterations    (i_iterations),
        .i_err_threshold (i_err_threshold),
        .i_rx_valid      (i_rx_valid),
        .i_rx_data       (i_rx_data),
        .o_lane_result   (o_lane_result),
        .o_done_check    (o_done_check),
        .o_busy          (o_busy)
`ifdef LANE_CHK_WORST_ERR_EN
        ,
        .o_worst_lane_errs (o_worst_lane_errs)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] emask[$];
    logic [15:0] exp_l;
    int          k;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] mask_at(input int idx);
        if (idx < emask.size())
            return emask[idx];
        return 16'h0000;
    endfunction

    function automatic int lane_errs(input int iters, input int lane);
        int          cnt;
        logic [15:0] m;
        cnt = 0;
        for (int b = 0; b < iters; b++) begin
            m = mask_at(b);
            cnt += int'(m[lane]);
        end
        return (cnt > 4095) ? 4095 : cnt;
    endfunction

    function automatic logic [15:0] model_result(input int iters, input logic [11:0] thr);
        logic [15:0] r;
        for (int lane = 0; lane < 16; lane++)
            r[lane] = (lane_errs(iters, lane) <= int'(thr));
        return r;
    endfunction

    function automatic int model_worst(input int iters);
        int w;
        w = 0;
        for (int lane = 0; lane < 16; lane++)
            if (lane_errs(iters, lane) > w) w = lane_errs(iters, lane);
        return w;
    endfunction

    task automatic fill_mask(input int n, input logic [15:0] m);
        emask.delete();
        for (int b = 0; b < n; b++) emask.push_back(m);
    endtask

    task automatic begin_run(input int iters, input logic [11:0] thr);
        @(negedge CLK);
        i_iterations    = 16'(iters);
        i_err_threshold = thr;
        i_start_check   = 1'b1;
        i_rx_valid      = 1'b0;
        exp_l           = 16'hACE1;
        k               = 0;
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input logic v);
        @(negedge CLK);
        i_rx_valid = v;
        i_rx_data  = v ? (exp_l ^ mask_at(k)) : 16'($urandom);
        @(posedge CLK);
        #1;
        if (v) begin
            exp_l = lfsr_step(exp_l);
            k++;
        end
    endtask

    task automatic end_run();
        @(negedge CLK);
        i_start_check = 1'b0;
        i_rx_valid    = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // vmode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid
    task automatic run(input int iters, input logic [11:0] thr, input int vmode,
                       output int bad_ctrl, output logic timed_out);
        int   cyc;
        logic v;
        bad_ctrl  = 0;
        timed_out = 1'b0;
        cyc       = 0;
        begin_run(iters, thr);
        if (iters > 0 && !(o_busy === 1'b1 && o_done_check === 1'b0)) bad_ctrl++;
        while (k < iters && !timed_out) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = cyc[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            step(v);
            cyc++;
            if (k < iters && !(o_busy === 1'b1 && o_done_check === 1'b0)) bad_ctrl++;
            if (cyc > iters * 4 + 20) timed_out = 1'b1;
        end
    endtask

    task automatic check_run_end(input string name, input int iters, input logic [11:0] thr,
                                 input logic [15:0] req, input int bad_ctrl, input logic timed_out);
        n_tests++;
        if (timed_out !== 1'b0 || bad_ctrl !== 0) begin
            n_fail++;
            $display("FAIL %s_ctrl: timeout=%0b bad_busy_done_cycles=%0d required 0/0", name, timed_out, bad_ctrl);
        end
        n_tests++;
        if (o_done_check !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b busy=%b required done=1 busy=0", name, o_done_check, o_busy);
        end
        n_tests++;
        if (o_lane_result !== req || req !== model_result(iters, thr)) begin
            n_fail++;
            $display("FAIL %s_result: got %h required %h (model %h)", name, o_lane_result, req,
                     model_result(iters, thr));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; i_start_check = 1'b0; i_iterations = '0; i_err_threshold = '0;
        i_rx_valid = 1'b0; i_rx_data = '0;
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_lane_result !== 16'h0 || o_done_check !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h done=%b busy=%b required 0000/0/0",
                     o_lane_result, o_done_check, o_busy);
        end
`ifdef LANE_CHK_WORST_ERR_EN
        n_tests++;
        if (o_worst_lane_errs !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_worst: got %0d required 0", o_worst_lane_errs);
        end
`endif
        repeat (3) @(posedge CLK);
        @(negedge CLK) rst_n = 1'b1;
    endtask

    task automatic test_clean();
        int bad; logic to;
        fill_mask(64, 16'h0000);
        run(64, 12'd0, 0, bad, to);
        check_run_end("clean64", 64, 12'd0, 16'hFFFF, bad, to);
        end_run();
        n_tests++;
        if (o_done_check !== 1'b0 || o_busy !== 1'b0 || o_lane_result !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL clean_release: done=%b busy=%b result=%h required 0/0/ffff",
                     o_done_check, o_busy, o_lane_result);
        end
    endtask

    task automatic test_lane_inverted();
        int bad; logic to;
        fill_mask(64, 16'h0008);
        run(64, 12'd0, 2, bad, to);
        check_run_end("lane3", 64, 12'd0, 16'hFFF7, bad, to);
`ifdef LANE_CHK_WORST_ERR_EN
        n_tests++;
        if (o_worst_lane_errs !== 12'(model_worst(64)) || model_worst(64) != 64) begin
            n_fail++;
            $display("FAIL lane3_worst: got %0d required 64", o_worst_lane_errs);
        end
`endif
        end_run();
        fill_mask(64, 16'hFF00);
        run(64, 12'd0, 0, bad, to);
        check_run_end("upper_inv", 64, 12'd0, 16'h00FF, bad, to);
        end_run();
        fill_mask(64, 16'h00FF);
        run(64, 12'd0, 2, bad, to);
        check_run_end("lower_inv", 64, 12'd0, 16'hFF00, bad, to);
        end_run();
    endtask

    task automatic test_threshold();
        int bad; logic to;
        fill_mask(32, 16'h0000);
        emask[3] = 16'h0020; emask[10] = 16'h0020; emask[17] = 16'h0020; emask[25] = 16'h0020;
        run(32, 12'd4, 0, bad, to);
        check_run_end("thr4", 32, 12'd4, 16'hFFFF, bad, to);
        end_run();
        run(32, 12'd3, 2, bad, to);
        check_run_end("thr3", 32, 12'd3, 16'hFFDF, bad, to);
        end_run();
        emask[25] = 16'h0000; emask[31] = 16'h0020;
        run(32, 12'd3, 0, bad, to);
        check_run_end("thr3_last", 32, 12'd3, 16'hFFDF, bad, to);
        end_run();
        run(32, 12'd4, 0, bad, to);
        check_run_end("thr4_last", 32, 12'd4, 16'hFFFF, bad, to);
        end_run();
    endtask

    task automatic test_valid_gaps();
        int bad; logic to;
        fill_mask(10, 16'h0000);
        run(10, 12'd0, 1, bad, to);
        check_run_end("gaps10", 10, 12'd0, 16'hFFFF, bad, to);
        end_run();
        fill_mask(4, 16'hFFFF);
        begin_run(0, 12'd0);
        n_tests++;
        if (o_done_check !== 1'b1 || o_busy !== 1'b0 || o_lane_result !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL iter0: done=%b busy=%b result=%h required 1/0/ffff",
                     o_done_check, o_busy, o_lane_result);
        end
        end_run();
    endtask

    task automatic test_random();
        int bad; logic to; int iters; logic [11:0] thr;
        for (int r = 0; r < 8; r++) begin
            iters = $urandom_range(1, 48);
            thr   = 12'($urandom_range(0, 3));
            emask.delete();
            for (int b = 0; b < iters; b++)
                emask.push_back(16'($urandom & $urandom & $urandom & $urandom));
            run(iters, thr, 2, bad, to);
            check_run_end($sformatf("rand%0d", r), iters, thr, model_result(iters, thr), bad, to);
            end_run();
        end
    endtask

    task automatic test_reset_abort();
        int bad; logic to;
        fill_mask(20, 16'hFF00);
        run(20, 12'd0, 0, bad, to);
        check_run_end("pre_abort", 20, 12'd0, 16'h00FF, bad, to);
        end_run();
        fill_mask(30, 16'h0000);
        begin_run(30, 12'd0);
        for (int i = 0; i < 5; i++) step(1'b1);
        @(negedge CLK) i_start_check = 1'b0;
        @(posedge CLK); #1;
        n_tests++;
        if (o_done_check !== 1'b0 || o_busy !== 1'b0 || o_lane_result !== 16'h00FF) begin
            n_fail++;
            $display("FAIL abort: done=%b busy=%b result=%h required 0/0/00ff",
                     o_done_check, o_busy, o_lane_result);
        end
        @(negedge CLK);
        run(16, 12'd0, 2, bad, to);
        check_run_end("restart", 16, 12'd0, 16'hFFFF, bad, to);
        end_run();
        begin_run(30, 12'd0);
        for (int i = 0; i < 4; i++) step(1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_lane_result !== 16'h0 || o_done_check !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: result=%h done=%b busy=%b required 0000/0/0",
                     o_lane_result, o_done_check, o_busy);
        end
        i_start_check = 1'b0;
        i_rx_valid    = 1'b0;
        @(posedge CLK);
        @(negedge CLK) rst_n = 1'b1;
        fill_mask(8, 16'h0000);
        emask[7] = 16'h8001;
        run(8, 12'd0, 0, bad, to);
        check_run_end("post_reset", 8, 12'd0, 16'h7FFE, bad, to);
        end_run();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_lane_inverted();
        test_threshold();
        test_valid_gaps();
        test_random();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_lane_pattern_checker.md
# rx_lane_pattern_checker

Receiver-side per-lane pattern checker for MBINIT data-to-clock training. It compares each mainband data lane against a locally generated LFSR pattern over a programmed number of beats and counts per-lane mismatches. It then produces the 16-bit per-lane pass vector that the functional-lane setup logic consumes to choose all lanes, the upper half or the lower half. It sits between the mainband RX deserializer and the MBINIT LTSM sub-state controller.

## Interface
- NUM_LANES, 16, number of mainband data lanes checked
- ITER_W, 16, width of beat-count programming
- ERR_W, 12, width of each per-lane saturating error counter
- CLK  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_start_check  input  1  level request from LTSM; held high for the whole check
- i_iterations  input  ITER_W  number of valid beats to compare; sampled on start
- i_err_threshold  input  ERR_W  max tolerated errors per lane; sampled on start
- i_rx_valid  input  1  one beat of i_rx_data present this cycle
- i_rx_data  input  NUM_LANES  one received bit per lane; bit i = lane i
- o_lane_result  output  NUM_LANES  bit i = 1 when lane i passed
- o_done_check  output  1  result valid; held until i_start_check drops
- o_busy  output  1  high while in CHECK

## Operation
- States: IDLE, CHECK, DONE.
- IDLE, i_start_check=1:
  - clear all error counters and the beat counter;
  - load the LFSR seed 16'hACE1;
  - latch i_iterations and i_err_threshold.
  - Go to CHECK, or to DONE with o_lane_result = all ones when i_iterations = 0.
- LFSR: 16-bit Fibonacci. fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
- Expected bit for lane i = l[i mod 16]. The LFSR advances only on a valid beat in CHECK, after the compare.
- CHECK, each i_rx_valid beat:
  - mismatch[i] = i_rx_data[i] ^ expected[i];
  - err[i] += mismatch[i], saturating at 2^ERR_W-1;
  - beat counter +1.
  - Cycles with i_rx_valid=0 change nothing.
- Last beat: when the beat counter equals latched iterations-1 and i_rx_valid=1, go to DONE. o_lane_result[i] = (err[i] + mismatch[i], saturated) <= latched threshold, so the final beat is included.
- Threshold 0 means zero tolerance. Comparison is unsigned.
- DONE: hold o_lane_result and o_done_check=1 while i_start_check=1. When i_start_check=0, go to IDLE and clear o_done_check. o_lane_result keeps its value.
- Abort: i_start_check=0 during CHECK returns to IDLE. o_lane_result stays unchanged and o_done_check stays 0.
- i_rx_valid in IDLE or DONE is ignored.

## Timing
- Reset values: o_lane_result = 0, o_done_check = 0, o_busy = 0, state IDLE, LFSR = 16'hACE1, all counters 0.
- Start detected at edge T:
  - CHECK and o_busy=1 from T+1;
  - the first compare uses the beat present in cycle T+1 or later.
- The last valid beat at edge E updates o_lane_result, sets o_done_check=1 and clears o_busy, all visible after E, in the same cycle.
- With iterations=0: o_done_check=1 one cycle after start.
- From i_start_check low in DONE, o_done_check=0 one cycle later. A new start needs at least one cycle in IDLE.
- Async reset in any state forces reset values immediately.
- All outputs are registered.

## Configuration
- LANE_CHK_WORST_ERR_EN defined: adds output o_worst_lane_errs [ERR_W-1:0] = maximum final saturated error count across all lanes.
  - Updated together with o_lane_result, reset value 0, held in IDLE.
- Undefined: the port and the max logic are absent. All other behaviour is identical.

## Test plan
- Clean pattern, iterations=64, threshold=0 -> o_lane_result=16'hFFFF; o_done_check rises on the edge of the 64th valid beat; o_busy high for exactly the CHECK cycles.
- Lane 3 inverted on every beat, iterations=64, threshold=0 -> 16'hFFF7; with LANE_CHK_WORST_ERR_EN, o_worst_lane_errs=64.
- Lanes 8-15 inverted on every beat -> 16'h00FF; lanes 0-7 inverted -> 16'hFF00.
- Lane 5 wrong on exactly 4 beats, iterations=32:
  - threshold=4 -> 16'hFFFF;
  - threshold=3 -> 16'hFFDF;
  - repeat with one of the errors on the final beat to prove it is counted.
- i_rx_valid toggling every other cycle, iterations=10, clean data -> LFSR advances only on valid beats, 16'hFFFF after the 10th valid beat; iterations=0 -> done after 1 cycle, 16'hFFFF.
- Reset and abort:
  - rst_n low mid-CHECK -> all outputs 0 at once;
  - i_start_check dropped mid-CHECK -> IDLE, o_done_check stays 0, previous o_lane_result retained;
  - a restart then gives the correct fresh result.
